// File: rtl/class_argmax_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// class_argmax_if
//   Count-input handshake and result bus of the class_argmax stage.
//   master: producer/consumer side, slave: the arg-max block.
//   Revision: 1.0
// ---------------------------------------------------------------------------
interface class_argmax_if #(
  parameter int NUM_CLASSES = 4,
  parameter int COUNT_WIDTH = 4
) ();
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                   start_i;
  logic [COUNT_WIDTH-1:0] count_i;
  logic                   count_valid_i;
  logic                   count_ready_o;
  logic                   result_ready_i;
  logic                   result_valid_o;
  logic [IDX_W-1:0]       class_o;
  logic [COUNT_WIDTH-1:0] max_count_o;
  logic                   tie_o;
  logic                   busy_o;

  modport master (
    output start_i, count_i, count_valid_i, result_ready_i,
    input  count_ready_o, result_valid_o, class_o, max_count_o, tie_o, busy_o
  );

  modport slave (
    input  start_i, count_i, count_valid_i, result_ready_i,
    output count_ready_o, result_valid_o, class_o, max_count_o, tie_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/class_argmax.sv
`default_nettype none
// ---------------------------------------------------------------------------
// class_argmax
//   Sequential arg-max over NUM_CLASSES per-class ones counts. Reports the
//   lowest-index winner, its count and a tie flag, held until acknowledged.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module class_argmax #(
  parameter int NUM_CLASSES = 4,
  parameter int COUNT_WIDTH = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  class_argmax_if.slave bus
);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       class_q, class_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic                   tie_q, tie_d;
  logic                   ready_q, valid_q, busy_q;

  // Next-state and datapath updates; flags are derived from the next state
  // so every output leaves a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    class_d = class_q;
    max_d   = max_q;
    tie_d   = tie_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_COLLECT;
          idx_d   = '0;
          class_d = '0;
          max_d   = '0;
          tie_d   = 1'b0;
        end
      end
      S_COLLECT: begin
        if (bus.start_i) begin
          // Restart wins over any count presented in the same cycle.
          idx_d   = '0;
          class_d = '0;
          max_d   = '0;
          tie_d   = 1'b0;
        end else if (bus.count_valid_i) begin
          if ((idx_q == '0) || (bus.count_i > max_q)) begin
            max_d   = bus.count_i;
            class_d = idx_q;
            tie_d   = 1'b0;
          end else if (bus.count_i == max_q) begin
            tie_d = 1'b1;
          end
          if (idx_q == C_LAST_IDX) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.result_ready_i) begin
          if (bus.start_i) begin
            state_d = S_COLLECT;
            idx_d   = '0;
            class_d = '0;
            max_d   = '0;
            tie_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, result and handshake registers with asynchronous clear.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      class_q <= '0;
      max_q   <= '0;
      tie_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      max_q   <= max_d;
      tie_q   <= tie_d;
      ready_q <= (state_d == S_COLLECT);
      valid_q <= (state_d == S_DONE);
      busy_q  <= (state_d == S_COLLECT);
    end
  end

  assign bus.count_ready_o  = ready_q;
  assign bus.result_valid_o = valid_q;
  assign bus.busy_o         = busy_q;
  assign bus.class_o        = class_q;
  assign bus.max_count_o    = max_q;
  assign bus.tie_o          = tie_q;
endmodule
`default_nettype wire

// File: tb/tb_class_argmax.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_class_argmax
//   Self-checking bench for class_argmax: directed frames plus random frames
//   checked against a reference arg-max computed over the whole frame.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_class_argmax;
  localparam int NC = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  class_argmax_if #(.NUM_CLASSES(NC), .COUNT_WIDTH(CW)) bus ();

  class_argmax #(.NUM_CLASSES(NC), .COUNT_WIDTH(CW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int frm[NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("start_ready", 32'(bus.count_ready_o), 1);
    chk("start_busy", 32'(bus.busy_o), 1);
  endtask

  // Present one count and hold it until the block takes it.
  task automatic feed(input int c, input int gap);
    bit acc;
    acc = 1'b0;
    bus.count_i       = CW'(c);
    bus.count_valid_i = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = bus.count_ready_o;
      step();
    end
    bus.count_valid_i = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    repeat (gap) step();
  endtask

  // Reference: winner is the first index holding the frame maximum; the tie
  // flag is set when that maximum appears more than once in the frame.
  task automatic check_result(input string name, input bit ack);
    int best, cls, neq;
    best = -1; cls = 0; neq = 0;
    for (int i = 0; i < NC; i++)
      if (frm[i] > best) begin best = frm[i]; cls = i; end
    for (int i = 0; i < NC; i++)
      if (frm[i] == best) neq++;
    chk({name, "_valid"}, 32'(bus.result_valid_o), 1);
    chk({name, "_class"}, 32'(bus.class_o), 32'(cls));
    chk({name, "_max"},   32'(bus.max_count_o), 32'(best));
    chk({name, "_tie"},   32'(bus.tie_o), (neq > 1) ? 1 : 0);
    chk({name, "_rdy0"},  32'(bus.count_ready_o), 0);
    chk({name, "_busy0"}, 32'(bus.busy_o), 0);
    step();
    step();
    chk({name, "_hold_valid"}, 32'(bus.result_valid_o), 1);
    chk({name, "_hold_class"}, 32'(bus.class_o), 32'(cls));
    chk({name, "_hold_max"},   32'(bus.max_count_o), 32'(best));
    if (ack) begin
      bus.result_ready_i = 1'b1;
      step();
      bus.result_ready_i = 1'b0;
      chk({name, "_ack_valid"}, 32'(bus.result_valid_o), 0);
      chk({name, "_ack_busy"},  32'(bus.busy_o), 0);
    end
  endtask

  // gap < 0 selects a random 0..2 cycle gap between counts.
  task automatic run_frame(input string name, input int gap, input bit ack);
    do_start();
    for (int i = 0; i < NC; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i == NC - 1) g = 0;
      if (i == NC - 1) chk({name, "_prevalid"}, 32'(bus.result_valid_o), 0);
      feed(frm[i], g);
    end
    check_result(name, ack);
  endtask

  task automatic set_frm(input int a, input int b, input int c, input int d);
    frm[0] = a; frm[1] = b; frm[2] = c; frm[3] = d;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_class"}, 32'(bus.class_o), 0);
    chk({name, "_max"},   32'(bus.max_count_o), 0);
    chk({name, "_tie"},   32'(bus.tie_o), 0);
    chk({name, "_valid"}, 32'(bus.result_valid_o), 0);
    chk({name, "_ready"}, 32'(bus.count_ready_o), 0);
    chk({name, "_busy"},  32'(bus.busy_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i        = 1'b0;
    bus.count_i        = '0;
    bus.count_valid_i  = 1'b0;
    bus.result_ready_i = 1'b0;
    #3;
    chk_all_zero("reset");
    #4 rst = 1'b0;
    step();

    // count_valid_i in IDLE must not start anything
    bus.count_valid_i = 1'b1;
    bus.count_i       = 4'd9;
    step();
    step();
    bus.count_valid_i = 1'b0;
    chk("idle_ready", 32'(bus.count_ready_o), 0);
    chk("idle_busy",  32'(bus.busy_o), 0);
    chk("idle_valid", 32'(bus.result_valid_o), 0);

    set_frm(3, 7, 2, 5);   run_frame("basic", 0, 1'b1);
    set_frm(5, 8, 8, 1);   run_frame("tie8", 0, 1'b1);
    set_frm(0, 0, 0, 0);   run_frame("zeros", 0, 1'b1);
    set_frm(4, 4, 6, 2);   run_frame("tieclr", 0, 1'b1);
    set_frm(1, 2, 3, 9);   run_frame("gaps", 2, 1'b1);
    set_frm(15, 3, 15, 0); run_frame("fullscale", 0, 1'b1);

    // restart mid-frame; the count presented with start is dropped
    do_start();
    feed(6, 0);
    feed(1, 0);
    bus.start_i       = 1'b1;
    bus.count_valid_i = 1'b1;
    bus.count_i       = 4'd15;
    step();
    bus.start_i       = 1'b0;
    bus.count_valid_i = 1'b0;
    chk("restart_ready", 32'(bus.count_ready_o), 1);
    chk("restart_max",   32'(bus.max_count_o), 0);
    set_frm(2, 3, 4, 1);
    for (int i = 0; i < NC; i++) feed(frm[i], 0);
    check_result("restart", 1'b1);

    // back-to-back: ack and start together in DONE
    set_frm(9, 2, 11, 11); run_frame("b2b_a", 0, 1'b0);
    bus.result_ready_i = 1'b1;
    bus.start_i        = 1'b1;
    step();
    bus.result_ready_i = 1'b0;
    bus.start_i        = 1'b0;
    chk("b2b_ready", 32'(bus.count_ready_o), 1);
    chk("b2b_valid", 32'(bus.result_valid_o), 0);
    set_frm(1, 12, 0, 7);
    for (int i = 0; i < NC; i++) feed(frm[i], 0);
    check_result("b2b_b", 1'b1);

    // random frames, narrow range on odd frames to provoke ties
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < NC; i++)
        frm[i] = (f % 2 == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      run_frame("rand", -1, 1'b1);
    end

    // asynchronous reset between edges after three accepts
    do_start();
    feed(3, 0);
    feed(7, 0);
    feed(2, 0);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("areset");
    #3 rst = 1'b0;
    step();
    set_frm(3, 7, 2, 5);
    run_frame("post_reset", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
